// File: rtl/idex_operand_stage_if.sv
// +------------------------------------------------------------------------+
// | Interface : idex_operand_stage_if                                      |
// | Purpose   : Bundles the decode-side inputs, forwarding sources and the |
// |             EX-side outputs of the ID/EX operand stage.                |
// | Modports  : master - drives id_*, stall, flush, mem_*, wb_*;           |
// |                      observes ex_* and hazard_stall                    |
// |             slave  - the operand stage itself                          |
// | Signals   : id_valid, id_rd1/id_rd2/id_imm (WIDTH), id_rs/id_rt/id_wr  |
// |             (RW), id_shamt (5), id_alucontrol (CW), id_alusrc,         |
// |             id_regwrite, id_memtoreg, id_memwrite, stall, flush,       |
// |             mem_regwrite/mem_wr/mem_aluout, wb_regwrite/wb_wr/         |
// |             wb_result, ex_valid, ex_a, ex_b, ex_storedata, ex_shamt,   |
// |             ex_alucontrol, ex_wr, ex_regwrite, ex_memtoreg,            |
// |             ex_memwrite, hazard_stall                                  |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
`default_nettype none

interface idex_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int RW    = 5,
  parameter int CW    = 5
);
  // Decode slot
  logic             id_valid;
  logic [WIDTH-1:0] id_rd1;
  logic [WIDTH-1:0] id_rd2;
  logic [WIDTH-1:0] id_imm;
  logic [RW-1:0]    id_rs;
  logic [RW-1:0]    id_rt;
  logic [RW-1:0]    id_wr;
  logic [4:0]       id_shamt;
  logic [CW-1:0]    id_alucontrol;
  logic             id_alusrc;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             id_memwrite;
  // Pipeline control
  logic             stall;
  logic             flush;
  // Writeback information from later stages
  logic             mem_regwrite;
  logic [RW-1:0]    mem_wr;
  logic [WIDTH-1:0] mem_aluout;
  logic             wb_regwrite;
  logic [RW-1:0]    wb_wr;
  logic [WIDTH-1:0] wb_result;
  // EX slot
  logic             ex_valid;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [WIDTH-1:0] ex_storedata;
  logic [4:0]       ex_shamt;
  logic [CW-1:0]    ex_alucontrol;
  logic [RW-1:0]    ex_wr;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_memwrite;
  logic             hazard_stall;

  modport master (
    output id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wr, id_shamt,
           id_alucontrol, id_alusrc, id_regwrite, id_memtoreg, id_memwrite,
           stall, flush, mem_regwrite, mem_wr, mem_aluout,
           wb_regwrite, wb_wr, wb_result,
    input  ex_valid, ex_a, ex_b, ex_storedata, ex_shamt, ex_alucontrol,
           ex_wr, ex_regwrite, ex_memtoreg, ex_memwrite, hazard_stall
  );

  modport slave (
    input  id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_wr, id_shamt,
           id_alucontrol, id_alusrc, id_regwrite, id_memtoreg, id_memwrite,
           stall, flush, mem_regwrite, mem_wr, mem_aluout,
           wb_regwrite, wb_wr, wb_result,
    output ex_valid, ex_a, ex_b, ex_storedata, ex_shamt, ex_alucontrol,
           ex_wr, ex_regwrite, ex_memtoreg, ex_memwrite, hazard_stall
  );
endinterface

`default_nettype wire

// File: rtl/idex_operand_stage.sv
// +------------------------------------------------------------------------+
// | Module    : idex_operand_stage                                         |
// | Purpose   : ID/EX pipeline register with EX-stage operand forwarding   |
// |             and hazard detection. Drives ALU operands, shamt and       |
// |             alucontrol, plus store data and control for EX/MEM.        |
// | Ports     : clk   - clock, rising edge                                 |
// |             reset - asynchronous, active-high                          |
// |             bus   - idex_operand_stage_if.slave (decode inputs,        |
// |                     MEM/WB writeback info, EX outputs, hazard_stall)   |
// | Config    : IDEX_FWD_EN defined   -> MEM/WB forwarding, load-use stall |
// |             IDEX_FWD_EN undefined -> no forwarding, stall on any RAW   |
// |                                      against EX or MEM                 |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
`default_nettype none

module idex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RW    = 5,
  parameter int CW    = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  idex_operand_stage_if.slave bus
);

  // EX slot registers
  logic             r_valid;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic [WIDTH-1:0] r_imm;
  logic [RW-1:0]    r_rs;
  logic [RW-1:0]    r_rt;
  logic [RW-1:0]    r_wr;
  logic [4:0]       r_shamt;
  logic [CW-1:0]    r_alucontrol;
  logic             r_alusrc;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_memwrite;

  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic             w_hazard;

`ifdef IDEX_FWD_EN
  // MEM result is younger than WB, so it wins on a simultaneous match.
  // r0 is hardwired zero and must never pick up a forwarded value.
  always_comb begin
    w_fwd_a = r_rd1;
    w_fwd_b = r_rd2;
    if (bus.mem_regwrite && (bus.mem_wr == r_rs) && (r_rs != '0)) begin
      w_fwd_a = bus.mem_aluout;
    end else if (bus.wb_regwrite && (bus.wb_wr == r_rs) && (r_rs != '0)) begin
      w_fwd_a = bus.wb_result;
    end
    if (bus.mem_regwrite && (bus.mem_wr == r_rt) && (r_rt != '0)) begin
      w_fwd_b = bus.mem_aluout;
    end else if (bus.wb_regwrite && (bus.wb_wr == r_rt) && (r_rt != '0)) begin
      w_fwd_b = bus.wb_result;
    end
  end

  // Only a load in EX cannot be forwarded in time: its data exists after MEM.
  // Gating with reset drops the request at once while reset is held.
  assign w_hazard = r_valid && r_memtoreg && (r_wr != '0) && bus.id_valid &&
                    ((r_wr == bus.id_rs) || (r_wr == bus.id_rt)) && !reset;
`else
  logic w_rs_busy;
  logic w_rt_busy;
  logic w_unused;

  assign w_fwd_a = r_rd1;
  assign w_fwd_b = r_rd2;

  // Without forwarding a source is unusable while any producer of it is
  // still in EX or MEM; WB is safe because the regfile writes first-half.
  assign w_rs_busy = (bus.id_rs != '0) &&
                     ((r_valid && r_regwrite && (r_wr == bus.id_rs)) ||
                      (bus.mem_regwrite && (bus.mem_wr == bus.id_rs)));
  assign w_rt_busy = (bus.id_rt != '0) &&
                     ((r_valid && r_regwrite && (r_wr == bus.id_rt)) ||
                      (bus.mem_regwrite && (bus.mem_wr == bus.id_rt)));
  assign w_hazard  = (w_rs_busy || w_rt_busy) && !reset;

  // Forwarding sources and registered source ids have no consumer here.
  assign w_unused = ^{bus.mem_aluout, bus.wb_regwrite, bus.wb_wr,
                      bus.wb_result, r_rs, r_rt};
`endif

  // Priority: reset > flush > hazard bubble > stall hold > capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wr         <= '0;
      r_shamt      <= '0;
      r_alucontrol <= '0;
      r_alusrc     <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memwrite   <= 1'b0;
    end else if (bus.flush || w_hazard) begin
      r_valid      <= 1'b0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wr         <= '0;
      r_shamt      <= '0;
      r_alucontrol <= '0;
      r_alusrc     <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memwrite   <= 1'b0;
    end else if (!bus.stall) begin
      r_valid      <= bus.id_valid;
      r_rd1        <= bus.id_rd1;
      r_rd2        <= bus.id_rd2;
      r_imm        <= bus.id_imm;
      r_rs         <= bus.id_rs;
      r_rt         <= bus.id_rt;
      r_wr         <= bus.id_wr;
      r_shamt      <= bus.id_shamt;
      r_alucontrol <= bus.id_alucontrol;
      r_alusrc     <= bus.id_alusrc;
      // An empty decode slot must not cause side effects downstream.
      r_regwrite   <= bus.id_valid && bus.id_regwrite;
      r_memtoreg   <= bus.id_valid && bus.id_memtoreg;
      r_memwrite   <= bus.id_valid && bus.id_memwrite;
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_a          = w_fwd_a;
  assign bus.ex_b          = r_alusrc ? r_imm : w_fwd_b;
  assign bus.ex_storedata  = w_fwd_b;
  assign bus.ex_shamt      = r_shamt;
  assign bus.ex_alucontrol = r_alucontrol;
  assign bus.ex_wr         = r_wr;
  assign bus.ex_regwrite   = r_regwrite;
  assign bus.ex_memtoreg   = r_memtoreg;
  assign bus.ex_memwrite   = r_memwrite;
  assign bus.hazard_stall  = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_idex_operand_stage.sv
// +------------------------------------------------------------------------+
// | Module    : tb_idex_operand_stage                                      |
// | Purpose   : Directed self-checking bench for idex_operand_stage. A     |
// |             slot-level model predicts every output each cycle; literal |
// |             expectations pin key scenarios. Honours IDEX_FWD_EN.       |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_idex_operand_stage;

`ifdef IDEX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  idex_operand_stage_if bus ();

  idex_operand_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int held_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Model: the EX slot as a record of what was issued into it.
  // ------------------------------------------------------------------
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, wr, shamt, aluc;
    logic        alusrc, regwrite, memtoreg, memwrite;
  } slot_t;

  slot_t m;

  // Value the ALU should see for register src whose file value was own.
  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] own);
    if (!FWD || src == 5'd0) return own;
    if (bus.mem_regwrite && bus.mem_wr == src) return bus.mem_aluout;
    if (bus.wb_regwrite && bus.wb_wr == src) return bus.wb_result;
    return own;
  endfunction

  // Is register src still being produced by an instruction the stage can't read from?
  function automatic bit pending(input logic [4:0] src);
    if (src == 5'd0) return 1'b0;
    if (FWD) return m.valid && m.memtoreg && m.wr == src;
    return (m.valid && m.regwrite && m.wr == src) || (bus.mem_regwrite && bus.mem_wr == src);
  endfunction

  function automatic bit want_stall();
    if (reset) return 1'b0;
    if (FWD && !bus.id_valid) return 1'b0;
    return pending(bus.id_rs) || pending(bus.id_rt);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '0;
    end else if (bus.flush || want_stall()) begin
      m <= '0;
    end else if (!bus.stall) begin
      m <= '{valid: bus.id_valid, rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm,
             rs: bus.id_rs, rt: bus.id_rt, wr: bus.id_wr, shamt: bus.id_shamt,
             aluc: bus.id_alucontrol, alusrc: bus.id_alusrc,
             regwrite: bus.id_valid & bus.id_regwrite,
             memtoreg: bus.id_valid & bus.id_memtoreg,
             memwrite: bus.id_valid & bus.id_memwrite};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] b_rt;
    b_rt = operand(m.rt, m.rd2);
    check("ex_valid",      32'(bus.ex_valid),      32'(m.valid));
    check("ex_a",          bus.ex_a,               operand(m.rs, m.rd1));
    check("ex_b",          bus.ex_b,               m.alusrc ? m.imm : b_rt);
    check("ex_storedata",  bus.ex_storedata,       b_rt);
    check("ex_shamt",      32'(bus.ex_shamt),      32'(m.shamt));
    check("ex_alucontrol", 32'(bus.ex_alucontrol), 32'(m.aluc));
    check("ex_wr",         32'(bus.ex_wr),         32'(m.wr));
    check("ex_regwrite",   32'(bus.ex_regwrite),   32'(m.regwrite));
    check("ex_memtoreg",   32'(bus.ex_memtoreg),   32'(m.memtoreg));
    check("ex_memwrite",   32'(bus.ex_memwrite),   32'(m.memwrite));
    check("hazard_stall",  32'(bus.hazard_stall),  32'(want_stall()));
  end

  // ------------------------------------------------------------------
  // Stimulus helpers; inputs change only just after a falling edge.
  // ------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] aluc, input logic alusrc,
                       input logic rw, input logic m2r, input logic mw);
    bus.id_valid      = v;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_wr         = wr;
    bus.id_rd1        = rd1;
    bus.id_rd2        = rd2;
    bus.id_imm        = imm;
    bus.id_shamt      = rd1[4:0] ^ 5'h0A;
    bus.id_alucontrol = aluc;
    bus.id_alusrc     = alusrc;
    bus.id_regwrite   = rw;
    bus.id_memtoreg   = m2r;
    bus.id_memwrite   = mw;
  endtask

  task automatic later(input logic mrw, input logic [4:0] mwr, input logic [31:0] mout,
                       input logic wrw, input logic [4:0] wwr, input logic [31:0] wres);
    bus.mem_regwrite = mrw;
    bus.mem_wr       = mwr;
    bus.mem_aluout   = mout;
    bus.wb_regwrite  = wrw;
    bus.wb_wr        = wwr;
    bus.wb_result    = wres;
  endtask

  initial begin
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    later(0, 0, 0, 0, 0, 0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    #1 reset = 1'b1;
    cyc();
    cyc();

    // Reset state
    check("rst_valid",  32'(bus.ex_valid), 32'd0);
    check("rst_a",      bus.ex_a,          32'd0);
    check("rst_b",      bus.ex_b,          32'd0);
    check("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    reset = 1'b0;

    // add r3 = r1 + r2 enters EX one edge after issue
    issue(1, 1, 2, 3, 32'h10, 32'h20, 0, 5'd2, 0, 1, 0, 0);
    cyc();
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    check("add_a",     bus.ex_a,          32'h10);
    check("add_b",     bus.ex_b,          32'h20);
    check("add_wr",    32'(bus.ex_wr),    32'd3);

`ifdef IDEX_FWD_EN
    // Consumer of r3 in EX; forwarding priority while held by stall
    issue(1, 3, 4, 6, 32'h11, 32'h44, 0, 5'd1, 0, 1, 0, 0);
    cyc();
    check("fwd_none_a", bus.ex_a, 32'h11);
    bus.stall = 1'b1;
    later(1, 3, 32'h55, 0, 0, 0);
    cyc();
    check("fwd_mem_a", bus.ex_a, 32'h55);
    later(1, 3, 32'h55, 1, 3, 32'h99);
    cyc();
    check("fwd_mem_beats_wb", bus.ex_a, 32'h55);
    later(1, 0, 32'h55, 1, 9, 32'h99);
    cyc();
    check("fwd_r0_ignored", bus.ex_a, 32'h11);
    later(1, 4, 32'h66, 1, 3, 32'h99);
    cyc();
    check("fwd_wb_a",  bus.ex_a,         32'h99);
    check("fwd_mem_b", bus.ex_storedata, 32'h66);
    bus.stall = 1'b0;
    later(0, 0, 0, 0, 0, 0);

    // lw r5 followed by a user of r5
    issue(1, 1, 0, 5, 32'h1000, 0, 32'h4, 5'd2, 1, 1, 1, 0);
    cyc();
    check("lw_b_imm", bus.ex_b, 32'h4);
    issue(1, 2, 5, 7, 32'h22, 32'h77, 0, 5'd2, 0, 1, 0, 0);
    #1;
    check("loaduse_hazard", 32'(bus.hazard_stall), 32'd1);
    cyc();
    check("loaduse_bubble", 32'(bus.ex_valid), 32'd0);
    check("loaduse_clear",  32'(bus.hazard_stall), 32'd0);
    later(1, 5, 32'h1004, 0, 0, 0);
    cyc();
    later(0, 0, 0, 1, 5, 32'hABC);
    #1;
    check("loaduse_wb_b",  bus.ex_b,         32'hABC);
    check("loaduse_wb_sd", bus.ex_storedata, 32'hABC);
    check("loaduse_a",     bus.ex_a,         32'h22);
    held_wr = 7;
    later(0, 0, 0, 0, 0, 0);
`else
    // Without forwarding, a reader of r7 waits until r7 has left MEM
    issue(1, 1, 2, 7, 32'h1, 32'h2, 0, 5'd2, 0, 1, 0, 0);
    cyc();
    issue(1, 7, 0, 8, 32'h70, 32'h80, 0, 5'd2, 0, 1, 0, 0);
    #1;
    check("nofwd_ex_hazard", 32'(bus.hazard_stall), 32'd1);
    cyc();
    check("nofwd_bubble1", 32'(bus.ex_valid), 32'd0);
    later(1, 7, 32'h5A, 0, 0, 0);
    #1;
    check("nofwd_mem_hazard", 32'(bus.hazard_stall), 32'd1);
    cyc();
    check("nofwd_bubble2", 32'(bus.ex_valid), 32'd0);
    later(0, 0, 0, 1, 7, 32'h99);
    #1;
    check("nofwd_wb_clear", 32'(bus.hazard_stall), 32'd0);
    cyc();
    check("nofwd_capture", 32'(bus.ex_valid), 32'd1);
    check("nofwd_a_raw",   bus.ex_a,          32'h70);
    held_wr = 8;
    later(0, 0, 0, 0, 0, 0);
`endif

    // Stall holds the EX slot for three edges
    bus.stall = 1'b1;
    issue(1, 10, 11, 12, 32'hAA, 32'hBB, 0, 5'd3, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_wr",    32'(bus.ex_wr),         32'(held_wr));
      check("stall_valid", 32'(bus.ex_valid),      32'd1);
      check("stall_aluc",  32'(bus.ex_alucontrol), 32'd2);
    end
    // Flush overrides stall
    bus.flush = 1'b1;
    cyc();
    check("flush_valid", 32'(bus.ex_valid),      32'd0);
    check("flush_aluc",  32'(bus.ex_alucontrol), 32'd0);
    check("flush_rw",    32'(bus.ex_regwrite),   32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    cyc();
    check("sw_valid", 32'(bus.ex_valid),    32'd1);
    check("sw_mw",    32'(bus.ex_memwrite), 32'd1);
    check("sw_wr",    32'(bus.ex_wr),       32'd12);

    // Empty decode slot: fields captured, side-effect controls forced off
    issue(0, 1, 2, 13, 32'h5, 32'h6, 0, 5'd4, 0, 1, 1, 1);
    cyc();
    check("inv_valid", 32'(bus.ex_valid),      32'd0);
    check("inv_rw",    32'(bus.ex_regwrite),   32'd0);
    check("inv_m2r",   32'(bus.ex_memtoreg),   32'd0);
    check("inv_mw",    32'(bus.ex_memwrite),   32'd0);
    check("inv_aluc",  32'(bus.ex_alucontrol), 32'd4);
    check("inv_a",     bus.ex_a,               32'h5);

    // Reset while a hazard is being requested
    issue(1, 1, 0, 5, 32'h1000, 0, 32'h4, 5'd2, 1, 1, 1, 0);
    cyc();
    issue(1, 2, 5, 7, 32'h22, 32'h77, 0, 5'd2, 0, 1, 0, 0);
    later(1, 2, 32'h33, 0, 0, 0);
    #1;
    check("pre_rst_hazard", 32'(bus.hazard_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_hazard", 32'(bus.hazard_stall), 32'd0);
    check("midrst_valid",  32'(bus.ex_valid),     32'd0);
    check("midrst_b",      bus.ex_b,              32'd0);
    check("midrst_wr",     32'(bus.ex_wr),        32'd0);
    cyc();
    reset = 1'b0;
    later(0, 0, 0, 0, 0, 0);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
